// File: rtl/cdf_pipeline.sv
// Histogram-to-CDF pass: streams NUM_BINS counts from scratchpad-1, writes the
// saturating running sum per bin to scratchpad-2, and reports min/total.
module cdf_pipeline #(
  parameter int NUM_BINS = 256,
  parameter int COUNT_W  = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               inputBaseOffset,
  input  logic [127:0]       m2ReadBus,
  output logic [15:0]        m2ReadAddr,
  output logic [15:0]        m3WriteAddr,
  output logic [127:0]       m3WriteBus,
  output logic               m3WE,
  output logic [COUNT_W-1:0] cdfMin,
  output logic [COUNT_W-1:0] cdfTotal,
  output logic               done
);

  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [15:0] VALID_TAG = 16'hAAAA;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   bin_reg;
  logic [1:0]         drain_reg;
  logic               base_reg;
  logic               rd_valid_reg;
  logic [15:0]        rd_addr_reg;
  logic [COUNT_W-1:0] sum_reg;
  logic               min_found_reg;

  logic [COUNT_W-1:0] count;
  logic [COUNT_W:0]   sum_wide;
  logic [COUNT_W-1:0] sum_new;
  logic [127:0]       write_word;
  logic               unused_bits;

  assign unused_bits = ^m2ReadBus[127:36];

  // Next-state and state-decoded outputs
  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    m2ReadAddr = {base_reg, 7'b0, 8'(bin_reg)};
    case (state_reg)
      IDLE:    if (start) state_next = READ;
      READ:    if (bin_reg == LAST_BIN) state_next = DRAIN;
      DRAIN:   if (drain_reg == 2'd2) state_next = DONE;
      DONE: begin
        done = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Untagged words are bins that were never seen and contribute nothing
  always_comb begin
    count      = (m2ReadBus[35:20] == VALID_TAG) ? m2ReadBus[COUNT_W-1:0] : '0;
    sum_wide   = {1'b0, sum_reg} + {1'b0, count};
    sum_new    = sum_wide[COUNT_W] ? '1 : sum_wide[COUNT_W-1:0];
    write_word = '0;
    write_word[35:20] = VALID_TAG;
    write_word[COUNT_W-1:0] = sum_new;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      bin_reg       <= '0;
      drain_reg     <= '0;
      base_reg      <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_addr_reg   <= '0;
      sum_reg       <= '0;
      min_found_reg <= 1'b0;
      m3WE          <= 1'b0;
      m3WriteAddr   <= '0;
      m3WriteBus    <= '0;
      cdfMin        <= '0;
      cdfTotal      <= '0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= (state_reg == READ);
      rd_addr_reg  <= m2ReadAddr;
      m3WE         <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          bin_reg       <= '0;
          drain_reg     <= '0;
          base_reg      <= inputBaseOffset;
          sum_reg       <= '0;
          min_found_reg <= 1'b0;
          cdfMin        <= '0;
          cdfTotal      <= '0;
        end
        READ:    if (bin_reg != LAST_BIN) bin_reg <= bin_reg + 1'b1;
        DRAIN:   drain_reg <= drain_reg + 2'd1;
        default: ;
      endcase
      // Data for the address issued two edges ago is on the bus now
      if (rd_valid_reg) begin
        sum_reg     <= sum_new;
        m3WE        <= 1'b1;
        m3WriteAddr <= rd_addr_reg;
        m3WriteBus  <= write_word;
        cdfTotal    <= sum_new;
        if (!min_found_reg && (sum_new != '0)) begin
          cdfMin        <= sum_new;
          min_found_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/cdf_pipeline.md
CDF_PIPELINE -- requirements
Module: cdf_pipeline

Interface
REQ-001 The block SHALL have exactly one clock, `clock`, and SHALL use a synchronous, active-high reset, `reset`, sampled on the rising edge of `clock`.
REQ-002 Parameter NUM_BINS, default 256, SHALL set the number of histogram bins processed.
REQ-003 Parameter COUNT_W, default 20, SHALL set the width of the count and cumulative sum.
REQ-004 Ports, in this order:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  level request; the histogram in m2 is complete
- inputBaseOffset  in  1  m2/m3 bank select; drives address bit 15
- m2ReadBus  in  128  scratchpad-1 read data; bits [35:0] are used
- m2ReadAddr  out  16  scratchpad-1 read address
- m3WriteAddr  out  16  scratchpad-2 write address
- m3WriteBus  out  128  scratchpad-2 write data
- m3WE  out  1  scratchpad-2 write enable
- cdfMin  out  COUNT_W  first nonzero cumulative value
- cdfTotal  out  COUNT_W  final cumulative value
- done  out  1  pass complete

Function
REQ-005 The FSM SHALL have four states: IDLE, READ, DRAIN and DONE.
REQ-006 IDLE SHALL go to READ on the first clock where start=1.
REQ-007 READ SHALL go to DRAIN after issuing bin NUM_BINS-1.
REQ-008 DRAIN SHALL go to DONE after the last write.
REQ-009 DONE SHALL go to IDLE when start=0.
REQ-010 In READ, the block SHALL issue one read per cycle, with m2ReadAddr = {inputBaseOffset, 7'b0, bin[7:0]}.
REQ-011 In READ, bin SHALL start at 0 and increment by 1 per cycle.
REQ-012 m2 read latency SHALL be exactly one cycle: data for the address issued in cycle k SHALL be sampled in cycle k+1.
REQ-013 A read word SHALL be valid only when m2ReadBus[35:20] == 16'hAAAA.
REQ-014 For a valid word, count = m2ReadBus[COUNT_W-1:0]; for an invalid word (bin never seen), count SHALL be 0.
REQ-015 The running sum SHALL reset to 0 when leaving IDLE.
REQ-016 The stage sampling m2 data SHALL update the sum to sum + count, saturating at all-ones (2^COUNT_W-1) with no wrap-around.
REQ-017 For each bin, the block SHALL write one word in cycle k+2:
- m3WE = 1
- m3WriteAddr = same address as issued for that bin
- m3WriteBus = {92'b0, 16'hAAAA, sum}
REQ-018 Writes SHALL be registered outputs.
REQ-019 The first write SHALL occur 2 cycles after the first read address.
REQ-020 The pass SHALL take exactly NUM_BINS writes in consecutive cycles, with no gaps or duplicates.
REQ-021 m3WE SHALL be 0 in IDLE and DONE, and in all cycles other than the NUM_BINS write cycles.
REQ-022 cdfMin SHALL latch the first post-add sum that is nonzero and SHALL NOT change afterward in that pass.
REQ-023 If all bins are zero, cdfMin SHALL remain 0.
REQ-024 cdfTotal SHALL equal the sum written for bin NUM_BINS-1, and SHALL be valid when done=1.
REQ-025 done SHALL be 1 only in DONE.
REQ-026 done SHALL rise exactly NUM_BINS+3 cycles after the IDLE->READ transition.
REQ-027 done SHALL stay high while start=1.
REQ-028 If start drops while in READ or DRAIN, the block SHALL complete the pass anyway; in DONE it then SHALL return to IDLE the next cycle.
REQ-029 If start is held high after done, no new pass SHALL begin until start has been 0 for at least one cycle.
REQ-030 inputBaseOffset SHALL be sampled at IDLE->READ and held constant for the pass.
REQ-031 Address generation SHALL NOT change when inputBaseOffset changes mid-pass.
REQ-032 m3WriteBus bits [127:36] SHALL always be 0.

Reset
REQ-033 reset=1 SHALL force all outputs to their reset values on the next edge, overriding all other inputs:
- FSM = IDLE
- m2ReadAddr = 0
- m3WriteAddr = 0
- m3WriteBus = 0
- m3WE = 0
- cdfMin = 0
- cdfTotal = 0
- done = 0
- sum = 0
- bin = 0
REQ-034 Reset asserted mid-pass SHALL abort the pass: no further writes, and m3WE = 0 from the cycle after reset is sampled.
REQ-035 After reset deasserts with start=1, a new pass SHALL begin from bin 0 on the next edge.

Verification
REQ-036 Uniform histogram: all bins valid with count 4, NUM_BINS=256 -> m3 bin i = {16'hAAAA, 4*(i+1)}; cdfMin=4; cdfTotal=1024; done at cycle 259.
REQ-037 Sparse histogram: only bins 10 (count 7) and 200 (count 3) valid, all others tag 0 -> bins 0-9 write 0; bins 10-199 write 7; bins 200-255 write 10; cdfMin=7; cdfTotal=10.
REQ-038 Saturation: bin 0 count 20'hFFFF0, bin 1 count 20'h00100 -> bin 1 and all later bins write 20'hFFFFF; no wrap-around.
REQ-039 Bank select: inputBaseOffset=1 at start -> all m2ReadAddr and m3WriteAddr equal 16'h8000+i; toggling inputBaseOffset mid-pass has no effect.
REQ-040 Reset at bin 100 -> m3WE=0 the next cycle and done=0; with start held high, a new pass restarts at bin 0 and completes normally.
REQ-041 Handshake: start held high after done -> no second pass; deassert start for 1 cycle, reassert -> second pass with identical results.
